// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift register sequencer: command opcodes and FSM states.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ROTL = 2'b01,
    OP_ROTR = 2'b10,
    OP_LSR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_datapath.sv
// Universal shift register: holds q and applies one load/rotate/shift per enabled edge.
module shift_datapath
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_nxt;

  // Per-step mux: the value q would take if this edge is enabled.
  always_comb begin
    q_nxt = q;
    case (mode)
      OP_LOAD: q_nxt = data;
      OP_ROTL: q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROTR: q_nxt = {q[0], q[WIDTH-1:1]};
      OP_LSR:  q_nxt = {1'b0, q[WIDTH-1:1]};
      default: q_nxt = q;
    endcase
  end

  // Register update, gated by the sequencer's enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for the universal shift register datapath.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high unless abort
// ST_LOAD  | one edge to copy the latched data into q
// ST_SHIFT | one rotate/shift per edge until remaining reaches 1
// ST_DONE  | one-cycle done pulse, no command accepted
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  state_e           state;
  state_e           state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             dp_en;
  logic [1:0]       dp_mode;

  assign cmd_ready = (state == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control; abort wins over any pending work.
  always_comb begin
    state_nxt = state;
    dp_en     = 1'b0;
    dp_mode   = op_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD) begin
            state_nxt = ST_LOAD;
          end else if (cmd_count == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          dp_en     = 1'b1;
          dp_mode   = OP_LOAD;
          state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else begin
          dp_en = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latches, captured only on accept so later cmd_* changes are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_LOAD;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
    end
  end

  // Step down-counter; saturates at zero so it can never wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
    end else if (accept) begin
      remaining <= (cmd_op == OP_LOAD) ? '0 : cmd_count;
    end else if (state == ST_SHIFT && !abort && remaining != '0) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  shift_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (dp_en),
    .mode    (dp_mode),
    .data    (data_q),
    .q       (q)
  );

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a queue of expected q values per edge.
module tb_shift_reg_sequencer;
  import shift_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] q;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_q = 8'h00;
  logic [7:0] exp_q[$];

  shift_reg_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .q         (q)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_step(input logic [7:0] v, input logic [1:0] op);
    logic [7:0] r;
    r = v;
    if (op == OP_ROTL) r = (v << 1) | (v >> 7);
    else if (op == OP_ROTR) r = (v >> 1) | (v << 7);
    else if (op == OP_LSR) r = v >> 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a command once the sequencer is ready; returns 1ns after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] data);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full command: expected q per working edge is queued up front and popped as edges occur.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] data);
    int steps;
    logic [7:0] m;
    m = model_q;
    if (op == OP_LOAD) begin
      steps = 1;
      m = data;
      exp_q.push_back(m);
    end else begin
      steps = int'(cnt);
      for (int i = 0; i < steps; i++) begin
        m = model_step(m, op);
        exp_q.push_back(m);
      end
    end
    issue(op, cnt, data);
    chk("accept_q_hold", q, model_q);
    for (int i = 0; i < steps; i++) begin
      chk("busy_in_work", busy, 1);
      chk("done_early", done, 0);
      tick();
      chk("step_q", q, exp_q.pop_front());
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    chk("ready_in_done", cmd_ready, 0);
    model_q = m;
    tick();
    chk("done_single", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    // Asynchronous reset while idle, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    tick();
    reset_n = 1'b1;
    tick();

    run_cmd(OP_LOAD, 3'd0, 8'hA5);
    chk("load_a5", q, 8'hA5);

    run_cmd(OP_ROTR, 3'd3, 8'h00);
    chk("rotr3_final", q, 8'hB4);

    run_cmd(OP_LOAD, 3'd5, 8'hFF);
    run_cmd(OP_LSR, 3'd7, 8'h00);
    chk("lsr7_final", q, 8'h01);

    run_cmd(OP_LOAD, 3'd0, 8'h81);
    run_cmd(OP_ROTL, 3'd1, 8'h00);
    chk("rotl1_final", q, 8'h03);

    run_cmd(OP_ROTL, 3'd0, 8'hEE);
    chk("rotl0_final", q, 8'h03);

    // Abort in IDLE only blocks acceptance.
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = OP_LOAD;
    cmd_data = 8'h99;
    #1;
    chk("abort_idle_ready", cmd_ready, 0);
    tick();
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_q", q, 8'h03);
    cmd_valid = 1'b0;
    abort = 1'b0;

    // Abort after two ROTR steps.
    run_cmd(OP_LOAD, 3'd0, 8'h01);
    issue(OP_ROTR, 3'd5, 8'h00);
    tick();
    chk("abort_step1", q, 8'h80);
    tick();
    chk("abort_step2", q, 8'h40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_q_hold", q, 8'h40);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    tick();
    chk("abort_q_hold2", q, 8'h40);
    chk("abort_no_done2", done, 0);
    model_q = 8'h40;

    // Abort during DONE is ignored.
    issue(OP_LOAD, 3'd0, 8'h55);
    tick();
    abort = 1'b1;
    chk("done_abort_pulse", done, 1);
    tick();
    abort = 1'b0;
    chk("done_abort_q", q, 8'h55);
    chk("done_abort_idle", busy, 0);
    model_q = 8'h55;

    // Command offered while busy with changing opcode: only the one at the IDLE edge counts.
    issue(OP_LOAD, 3'd0, 8'h3C);
    cmd_valid = 1'b1;
    cmd_op = OP_ROTR;
    cmd_count = 3'd2;
    tick();
    chk("offer_load_q", q, 8'h3C);
    chk("offer_ready_done", cmd_ready, 0);
    cmd_op = OP_LSR;
    cmd_count = 3'd1;
    tick();
    chk("offer_idle", busy, 0);
    cmd_op = OP_ROTL;
    cmd_count = 3'd1;
    tick();
    cmd_valid = 1'b0;
    chk("offer_accept_busy", busy, 1);
    chk("offer_accept_q", q, 8'h3C);
    tick();
    chk("offer_result", q, model_step(8'h3C, OP_ROTL));
    chk("offer_done", done, 1);
    tick();
    model_q = q;

    // Reset dropped mid-SHIFT clears q immediately and issues no done.
    run_cmd(OP_LOAD, 3'd0, 8'hF0);
    issue(OP_ROTL, 3'd7, 8'h00);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_q", q, 8'h00);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_done", done, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_after_done", done, 0);
      chk("rst_after_q", q, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
